// File: rtl/bomb_blast_map_writer.sv
// Writable 16x8 tile map with a one-probe-per-cycle blast walker.
// Serves a registered renderer read port and reports cleared bricks.
module bomb_blast_map_writer #(
    parameter int MAP_COLS = 16,
    parameter int MAP_ROWS = 8,
    localparam int CW = $clog2(MAP_COLS),
    localparam int RW = $clog2(MAP_ROWS)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          wr_req,
    input  logic [CW-1:0] wr_col,
    input  logic [RW-1:0] wr_row,
    input  logic [3:0]    wr_code,
    output logic          wr_ack,
    input  logic          blast_req,
    input  logic [CW-1:0] blast_col,
    input  logic [RW-1:0] blast_row,
    input  logic [1:0]    blast_radius,
    output logic          busy,
    output logic          blast_done,
    output logic          brick_hit,
    output logic [CW-1:0] hit_col,
    output logic [RW-1:0] hit_row,
    output logic [2:0]    hit_count,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [3:0]    rd_code
);

    typedef enum logic [2:0] {
        IDLE, CENTER, RIGHT, LEFT, DOWN, UP, DONE
    } state_t;

    localparam logic [CW:0] COL_LIM = (CW+1)'(MAP_COLS);
    localparam logic [RW:0] ROW_LIM = (RW+1)'(MAP_ROWS);

    state_t        state;
    logic [CW-1:0] bCol;
    logic [RW-1:0] bRow;
    logic [1:0]    rad;
    logic [1:0]    step;
    logic [3:0]    tileMap [MAP_ROWS][MAP_COLS];

    logic [CW:0]   sumCol;
    logic [RW:0]   sumRow;
    logic [CW-1:0] stepC;
    logic [RW-1:0] stepR;
    logic [CW-1:0] pCol;
    logic [RW-1:0] pRow;
    logic          oob;
    logic [3:0]    pCode;
    logic          isBrick;
    logic          stopDir;
    logic          lastStep;

    assign stepC  = CW'(step);
    assign stepR  = RW'(step);
    assign sumCol = {1'b0, bCol} + (CW+1)'(step);
    assign sumRow = {1'b0, bRow} + (RW+1)'(step);

    // Address of the tile probed this cycle, plus its bounds check.
    always_comb begin
        pCol = bCol;
        pRow = bRow;
        oob  = 1'b0;
        case (state)
            RIGHT: begin
                pCol = sumCol[CW-1:0];
                oob  = sumCol >= COL_LIM;
            end
            LEFT: begin
                pCol = bCol - stepC;
                oob  = stepC > bCol;
            end
            DOWN: begin
                pRow = sumRow[RW-1:0];
                oob  = sumRow >= ROW_LIM;
            end
            UP: begin
                pRow = bRow - stepR;
                oob  = stepR > bRow;
            end
            default: ;
        endcase
    end

    assign pCode    = tileMap[pRow][pCol];
    assign isBrick  = !oob && (pCode == 4'd2);
    assign stopDir  = oob || (pCode == 4'd1) || (pCode == 4'd2);
    assign lastStep = stopDir || (step == rad);

    function automatic state_t nextDir(input state_t s);
        case (s)
            RIGHT:   return LEFT;
            LEFT:    return DOWN;
            DOWN:    return UP;
            default: return DONE;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int r = 0; r < MAP_ROWS; r++) begin
                for (int c = 0; c < MAP_COLS; c++) begin
                    tileMap[r][c] <= (r[0] && c[0]) ? 4'd1 : 4'd0;
                end
            end
            state      <= IDLE;
            bCol       <= '0;
            bRow       <= '0;
            rad        <= 2'd0;
            step       <= 2'd0;
            wr_ack     <= 1'b0;
            busy       <= 1'b0;
            blast_done <= 1'b0;
            brick_hit  <= 1'b0;
            hit_col    <= '0;
            hit_row    <= '0;
            hit_count  <= 3'd0;
            rd_code    <= 4'd0;
        end else begin
            wr_ack     <= 1'b0;
            brick_hit  <= 1'b0;
            blast_done <= 1'b0;
            rd_code    <= tileMap[rd_row][rd_col];
            case (state)
                IDLE: begin
                    if (blast_req) begin
                        bCol      <= blast_col;
                        bRow      <= blast_row;
                        rad       <= (blast_radius == 2'd0)
                                   ? 2'd1 : blast_radius;
                        step      <= 2'd1;
                        hit_count <= 3'd0;
                        busy      <= 1'b1;
                        state     <= CENTER;
                    end else if (wr_req && !wr_ack) begin
                        tileMap[wr_row][wr_col] <= wr_code;
                        wr_ack <= 1'b1;
                    end
                end
                CENTER, RIGHT, LEFT, DOWN, UP: begin
                    if (isBrick) begin
                        tileMap[pRow][pCol] <= 4'd0;
                        brick_hit <= 1'b1;
                        hit_col   <= pCol;
                        hit_row   <= pRow;
                        if (hit_count != 3'd4)
                            hit_count <= hit_count + 3'd1;
                    end
                    // The bomb tile never ends the walk early.
                    if (state == CENTER) begin
                        step  <= 2'd1;
                        state <= RIGHT;
                    end else if (lastStep) begin
                        step       <= 2'd1;
                        state      <= nextDir(state);
                        blast_done <= (state == UP);
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_blast_map_writer.sv
// Randomized bench for bomb_blast_map_writer against a tile-level
// model of the blast rules and the single-tile write port.
module tb_bomb_blast_map_writer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       wr_req;
    logic [3:0] wr_col;
    logic [2:0] wr_row;
    logic [3:0] wr_code;
    logic       wr_ack;
    logic       blast_req;
    logic [3:0] blast_col;
    logic [2:0] blast_row;
    logic [1:0] blast_radius;
    logic       busy;
    logic       blast_done;
    logic       brick_hit;
    logic [3:0] hit_col;
    logic [2:0] hit_row;
    logic [2:0] hit_count;
    logic [3:0] rd_col;
    logic [2:0] rd_row;
    logic [3:0] rd_code;

    always #5 clk = ~clk;

    bomb_blast_map_writer dut (
        .clk(clk), .resetN(resetN),
        .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row),
        .wr_code(wr_code), .wr_ack(wr_ack),
        .blast_req(blast_req), .blast_col(blast_col),
        .blast_row(blast_row), .blast_radius(blast_radius),
        .busy(busy), .blast_done(blast_done),
        .brick_hit(brick_hit), .hit_col(hit_col),
        .hit_row(hit_row), .hit_count(hit_count),
        .rd_col(rd_col), .rd_row(rd_row), .rd_code(rd_code)
    );

    int checks = 0;
    int failures = 0;

    logic [3:0] m [8][16];
    int mP;
    int mHitC[$];
    int mHitR[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                m[r][c] = ((r % 2) == 1 && (c % 2) == 1) ? 4'd1 : 4'd0;
    endfunction

    function automatic void model_blast(int col, int row, int rad);
        int rr;
        rr = (rad == 0) ? 1 : rad;
        mHitC.delete();
        mHitR.delete();
        mP = 1;
        if (m[row][col] == 4'd2) begin
            m[row][col] = 4'd0;
            mHitC.push_back(col);
            mHitR.push_back(row);
        end
        for (int d = 0; d < 4; d++) begin
            for (int k = 1; k <= rr; k++) begin
                int c;
                int r;
                c = col;
                r = row;
                case (d)
                    0: c = col + k;
                    1: c = col - k;
                    2: r = row + k;
                    default: r = row - k;
                endcase
                mP++;
                if (c < 0 || c > 15 || r < 0 || r > 7) break;
                if (m[r][c] == 4'd1) break;
                if (m[r][c] == 4'd2) begin
                    m[r][c] = 4'd0;
                    mHitC.push_back(c);
                    mHitR.push_back(r);
                    break;
                end
            end
        end
    endfunction

    task automatic read_tile(string name, int col, int row, int exp);
        rd_col = 4'(col);
        rd_row = 3'(row);
        tick();
        checks++;
        if (rd_code !== 4'(exp)) begin
            failures++;
            $display("FAIL %s rd(%0d,%0d) got=%0d exp=%0d",
                     name, col, row, rd_code, exp);
        end
    endtask

    task automatic check_map(string name);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_col = 4'(c);
                rd_row = 3'(r);
                tick();
                checks++;
                if (rd_code !== m[r][c]) begin
                    failures++;
                    $display("FAIL %s map(%0d,%0d) got=%0d exp=%0d",
                             name, c, r, rd_code, m[r][c]);
                end
            end
        end
    endtask

    task automatic do_write(int col, int row, int code);
        logic [3:0] old;
        int lat;
        old = m[row][col];
        wr_col  = 4'(col);
        wr_row  = 3'(row);
        wr_code = 4'(code);
        rd_col  = 4'(col);
        rd_row  = 3'(row);
        wr_req  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (wr_ack !== 1'b1 && lat < 20);
        wr_req = 1'b0;
        m[row][col] = 4'(code);
        checks++;
        if (wr_ack !== 1'b1 || lat != 1) begin
            failures++;
            $display("FAIL wr_latency got=%0d ack=%b exp=1", lat, wr_ack);
        end
        checks++;
        if (rd_code !== old) begin
            failures++;
            $display("FAIL rd_same_cycle got=%0d exp=%0d", rd_code, old);
        end
        tick();
        checks++;
        if (wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_pulse got=%b exp=0", wr_ack);
        end
        checks++;
        if (rd_code !== 4'(code)) begin
            failures++;
            $display("FAIL rd_after_wr got=%0d exp=%0d", rd_code, code);
        end
    endtask

    task automatic start_blast(int col, int row, int rad);
        blast_col    = 4'(col);
        blast_row    = 3'(row);
        blast_radius = 2'(rad);
        blast_req    = 1'b1;
        tick();
        blast_req = 1'b0;
    endtask

    task automatic observe_walk(string name, bit poke);
        int cyc;
        int done;
        int wrB;
        int n;
        int exH;
        int hc[$];
        int hr[$];
        cyc = 0;
        done = 0;
        wrB = 0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            cyc++;
            n++;
            if (brick_hit === 1'b1) begin
                hc.push_back(int'(hit_col));
                hr.push_back(int'(hit_row));
            end
            if (blast_done === 1'b1) done++;
            if (wr_ack === 1'b1) wrB++;
            if (poke && cyc == 2) begin
                blast_col    = 4'($urandom);
                blast_row    = 3'($urandom);
                blast_radius = 2'($urandom);
                blast_req    = 1'b1;
            end
            if (cyc == 3) blast_req = 1'b0;
            tick();
        end
        blast_req = 1'b0;
        checks++;
        if (cyc != mP + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d busy=%b",
                     name, cyc, mP + 1, busy);
        end
        checks++;
        if (done != 1 || blast_done !== 1'b0) begin
            failures++;
            $display("FAIL %s blast_done got=%0d exp=1", name, done);
        end
        checks++;
        if (wrB != 0 || brick_hit !== 1'b0) begin
            failures++;
            $display("FAIL %s wr_ack_busy got=%0d exp=0", name, wrB);
        end
        checks++;
        if (hc.size() != mHitC.size()) begin
            failures++;
            $display("FAIL %s hits got=%0d exp=%0d",
                     name, hc.size(), mHitC.size());
        end else begin
            for (int i = 0; i < hc.size(); i++) begin
                checks++;
                if (hc[i] != mHitC[i] || hr[i] != mHitR[i]) begin
                    failures++;
                    $display("FAIL %s hit%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             name, i, hc[i], hr[i], mHitC[i], mHitR[i]);
                end
            end
        end
        exH = (mHitC.size() > 4) ? 4 : mHitC.size();
        checks++;
        if (hit_count !== 3'(exH)) begin
            failures++;
            $display("FAIL %s hit_count got=%0d exp=%0d",
                     name, hit_count, exH);
        end
        if (poke) begin
            tick();
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s queued_blast busy=%b exp=0", name, busy);
            end
        end
    endtask

    task automatic run_blast(string name, int col, int row,
                             int rad, bit poke);
        model_blast(col, row, rad);
        start_blast(col, row, rad);
        observe_walk(name, poke);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || hit_count !== 3'd0 || rd_code !== 4'd0 ||
            wr_ack !== 1'b0 || blast_done !== 1'b0 ||
            brick_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b hc=%0d rd=%0d exp=0",
                     busy, hit_count, rd_code);
        end
        resetN = 1'b1;
        model_reset();
        read_tile("reset", 1, 1, 1);
        read_tile("reset", 2, 1, 0);
        read_tile("reset", 15, 7, 1);
        read_tile("reset", 0, 0, 0);
        check_map("reset_map");
    endtask

    task automatic test_write();
        do_write(4, 2, 2);
        read_tile("write", 4, 2, 2);
    endtask

    task automatic test_blast_spec();
        run_blast("spec", 2, 2, 3, 1'b0);
        checks++;
        if (hit_count !== 3'd1 || hit_col !== 4'd4 || hit_row !== 3'd2) begin
            failures++;
            $display("FAIL spec_hit got=%0d@(%0d,%0d) exp=1@(4,2)",
                     hit_count, hit_col, hit_row);
        end
        read_tile("spec", 4, 2, 0);
    endtask

    task automatic test_corner();
        run_blast("corner", 0, 0, 1, 1'b0);
        check_map("corner_map");
    endtask

    task automatic test_column();
        do_write(1, 4, 2);
        run_blast("column", 1, 2, 2, 1'b0);
        read_tile("column", 1, 4, 2);
    endtask

    task automatic test_radius0();
        do_write(9, 4, 2);
        run_blast("radius0", 8, 4, 0, 1'b0);
        read_tile("radius0", 9, 4, 0);
    endtask

    task automatic test_saturation();
        do_write(6, 4, 2);
        do_write(7, 4, 2);
        do_write(5, 4, 2);
        do_write(6, 5, 2);
        do_write(6, 3, 2);
        run_blast("saturate", 6, 4, 3, 1'b1);
        checks++;
        if (hit_count !== 3'd4) begin
            failures++;
            $display("FAIL saturate_count got=%0d exp=4", hit_count);
        end
    endtask

    task automatic test_back_to_back();
        do_write(12, 6, 2);
        run_blast("b2b_a", 12, 6, 2, 1'b0);
        run_blast("b2b_b", 13, 6, 3, 1'b0);
        run_blast("b2b_c", 3, 0, 2, 1'b0);
    endtask

    task automatic test_contention();
        int lat;
        model_blast(6, 2, 2);
        wr_col       = 4'd3;
        wr_row       = 3'd6;
        wr_code      = 4'd2;
        wr_req       = 1'b1;
        blast_col    = 4'd6;
        blast_row    = 3'd2;
        blast_radius = 2'd2;
        blast_req    = 1'b1;
        tick();
        blast_req = 1'b0;
        observe_walk("contend", 1'b0);
        lat = 0;
        while (wr_ack !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        wr_req = 1'b0;
        m[6][3] = 4'd2;
        checks++;
        if (wr_ack !== 1'b1 || lat != 1) begin
            failures++;
            $display("FAIL contend_wr_ack got=%0d exp=1", lat);
        end
        tick();
        read_tile("contend", 3, 6, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int sel;
                int code;
                sel = int'($urandom_range(0, 7));
                if (sel < 3) code = 2;
                else if (sel == 3) code = 1;
                else if (sel == 4) code = 0;
                else code = int'($urandom_range(3, 15));
                do_write(int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 7)), code);
            end else begin
                run_blast("random", int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            end
        end
        check_map("random_map");
    endtask

    task automatic test_reset_midwalk();
        int seen;
        do_write(2, 2, 2);
        start_blast(2, 2, 3);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (blast_done === 1'b1) seen++;
            tick();
        end
        resetN = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || blast_done !== 1'b0 ||
            hit_count !== 3'd0) begin
            failures++;
            $display("FAIL midreset busy=%b done=%b hc=%0d exp=0",
                     busy, blast_done, hit_count);
        end
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (blast_done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_done got=%0d exp=0", seen);
        end
        model_reset();
        check_map("midreset_map");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN       = 1'b0;
        wr_req       = 1'b0;
        wr_col       = 4'd0;
        wr_row       = 3'd0;
        wr_code      = 4'd0;
        blast_req    = 1'b0;
        blast_col    = 4'd0;
        blast_row    = 3'd0;
        blast_radius = 2'd0;
        rd_col       = 4'd0;
        rd_row       = 3'd0;
        model_reset();
        test_reset();
        test_write();
        test_blast_spec();
        test_corner();
        test_column();
        test_radius0();
        test_saturation();
        test_back_to_back();
        test_contention();
        test_random();
        test_reset_midwalk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
